// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use detection and variable-latency memory stall control
// for the pipelined MIPS core, with a hung-memory timeout and a stall-cycle counter.
module hazard_forward_unit #(
   parameter int REG_BITS    = 5,
   parameter int NUM_SRC     = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         id_valid,
   input  logic [NUM_SRC*REG_BITS-1:0]  id_src,
   input  logic [NUM_SRC*REG_BITS-1:0]  ex_src,
   input  logic [REG_BITS-1:0]          id_ex_rd,
   input  logic                         id_ex_memread,
   input  logic [REG_BITS-1:0]          ex_mem_rd,
   input  logic                         ex_mem_regwrite,
   input  logic                         ex_mem_memread,
   input  logic [REG_BITS-1:0]          mem_wb_rd,
   input  logic                         mem_wb_regwrite,
   input  logic                         mem_ready,
   output logic [NUM_SRC*2-1:0]         fwd_sel,
   output logic                         stall,
   output logic                         bubble,
   output logic                         mem_err,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST =
      WCNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t              state, state_nxt;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
   logic                err_set;
   logic                load_use;
   logic                mem_busy;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (!en || (&v))
         return v;
      return v + 1'b1;
   endfunction

   // Loads in EX/MEM have no result yet, so only MEM/WB may supply their data.
   always_comb begin
      fwd_sel = '0;
      if (rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_regwrite && (ex_mem_rd != '0) && !ex_mem_memread &&
                (ex_mem_rd == ex_src[i*REG_BITS +: REG_BITS]))
               fwd_sel[2*i +: 2] = 2'b10;
            else if (mem_wb_regwrite && (mem_wb_rd != '0) &&
                     (mem_wb_rd == ex_src[i*REG_BITS +: REG_BITS]))
               fwd_sel[2*i +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_ex_rd == id_src[i*REG_BITS +: REG_BITS])
            load_use = 1'b1;
      end
      load_use = load_use & id_valid & id_ex_memread & (id_ex_rd != '0);
      mem_busy = ex_mem_memread & !mem_ready;
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      err_set   = 1'b0;
      stall     = 1'b0;
      bubble    = 1'b0;
      case (state)
         RUN: begin
            stall  = load_use | mem_busy;
            bubble = load_use & !mem_busy;
            if (mem_busy) begin
               wcnt_nxt = WCNT_W'(1);
               if (MEM_TIMEOUT == 1) begin
                  state_nxt = ERR;
                  err_set   = 1'b1;
               end else begin
                  state_nxt = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            stall = !mem_ready;
            if (mem_ready) begin
               state_nxt = RUN;
               wcnt_nxt  = '0;
            end else if ((MEM_TIMEOUT != 0) && (wcnt == WCNT_LAST)) begin
               state_nxt = ERR;
               err_set   = 1'b1;
            end else if (MEM_TIMEOUT != 0) begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         ERR: begin
            stall = 1'b1;
         end
         default: begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
         end
      endcase
      if (!rst_n) begin
         stall  = 1'b0;
         bubble = 1'b0;
      end
   end

   // Control and status registers update on every rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         wcnt      <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         wcnt      <= wcnt_nxt;
         stall_cnt <= sat_inc(stall_cnt, stall);
         if (err_set)
            mem_err <= 1'b1;
      end
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard-control unit for the pipelined MIPS core; successor to the two-operand combinational forwarding logic. Generates per-operand ALU forwarding selects for `NUM_SRC` EX-stage operands, detects load-use hazards in ID, and freezes the pipeline while a variable-latency data memory completes a load. A timeout FSM flags a hung memory, and a saturating counter records stall cycles for performance analysis.

## Interface
- `REG_BITS`, 5, register-index width.
- `NUM_SRC`, 2, number of source operands per instruction.
- `MEM_TIMEOUT`, 16, number of consecutive busy-load cycles before error; 0 disables the timeout.
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: the ID-stage instruction is real, not a bubble.
- `id_src` in NUM_SRC*REG_BITS: ID-stage source indices; operand i occupies `[i*REG_BITS +: REG_BITS]`.
- `ex_src` in NUM_SRC*REG_BITS: ID/EX source indices, same packing.
- `id_ex_rd` in REG_BITS, `id_ex_memread` in 1: destination and load flag of the instruction in EX.
- `ex_mem_rd` in REG_BITS, `ex_mem_regwrite` in 1, `ex_mem_memread` in 1: EX/MEM destination, write enable and load flag.
- `mem_wb_rd` in REG_BITS, `mem_wb_regwrite` in 1: MEM/WB destination and write enable.
- `mem_ready` in 1: data memory has completed the access in MEM.
- `fwd_sel` out NUM_SRC*2: operand i select at `[2i+1:2i]`.
  - 00: register file.
  - 10: EX/MEM ALU result.
  - 01: MEM/WB result.
- `stall` out 1: freeze PC, IF/ID and ID/EX.
- `bubble` out 1: insert a NOP into ID/EX this cycle.
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_cnt` out CNT_W: saturating count of cycles with `stall`=1.

## Operation
- Forwarding, per operand i (combinational):
  - Select 10 if `ex_mem_regwrite`, `ex_mem_rd`≠0, `!ex_mem_memread` and `ex_mem_rd`==`ex_src[i]`.
  - Otherwise select 01 if `mem_wb_regwrite`, `mem_wb_rd`≠0 and `mem_wb_rd`==`ex_src[i]`.
  - Otherwise select 00.
  - EX/MEM always has priority over MEM/WB. Register 0 is never forwarded.
- Hazard terms:
  - `load_use` = `id_valid` & `id_ex_memread` & `id_ex_rd`≠0 & (`id_ex_rd`==`id_src[i]` for any i).
  - `mem_busy` = `ex_mem_memread` & `!mem_ready`.
- FSM states: RUN, MEM_WAIT, ERR. A 0..MEM_TIMEOUT wait counter `wcnt` backs the timeout.
- RUN:
  - `stall` = `load_use` | `mem_busy`.
  - `bubble` = `load_use` & `!mem_busy`.
  - If `mem_busy`: `wcnt`←1, go to MEM_WAIT. If additionally MEM_TIMEOUT==1, go to ERR instead.
- MEM_WAIT:
  - `stall` = `!mem_ready`, `bubble`=0 (whole pipe frozen).
  - If `mem_ready`: go to RUN, `wcnt`←0.
  - Else if MEM_TIMEOUT≠0 and `wcnt`==MEM_TIMEOUT-1: go to ERR, `mem_err`←1.
  - Else `wcnt`++.
- ERR:
  - `stall`=1, `bubble`=0, `mem_err`=1.
  - Exit only via reset. `fwd_sel` is still computed.
- Simultaneous `load_use` and `mem_busy`: the memory stall wins and `bubble`=0. The load-use check is re-evaluated after release.
- `stall_cnt` increments on every cycle with `stall`=1 and holds at 2^CNT_W−1.

## Timing
- Reset, while `rst_n`=0 at an edge: state←RUN, `wcnt`←0, `mem_err`←0, `stall_cnt`←0.
- While `rst_n` is low, `fwd_sel`, `stall` and `bubble` are forced to 0.
- `fwd_sel`, `stall` and `bubble` are combinational: zero latency from inputs.
- `mem_err` and `stall_cnt` are registered: they reflect a cycle's condition after the next edge.
- Load-use: exactly one stall/bubble cycle per hazard, assuming the load leaves EX.
- Memory wait: `stall` is high in every cycle where `mem_ready`=0. `stall` drops in the same cycle `mem_ready` rises.
- Timeout: `mem_err` rises after MEM_TIMEOUT consecutive busy cycles (cycle 0 in RUN plus MEM_TIMEOUT-1 cycles in MEM_WAIT).
- Reset asserted in MEM_WAIT or ERR returns the FSM to RUN on that edge.

## Test plan
- ALU chain: `ex_src`={rs=3, rt=4}, `ex_mem_rd`=3 with regwrite, `mem_wb_rd`=4 with regwrite → `fwd_sel`=01_10. With both rd=3, operand 0 is 10 (EX/MEM priority).
- Register 0 and load in EX/MEM: `ex_mem_rd`=0 with regwrite → 00. `ex_mem_rd`=5, memread, regwrite, `mem_wb_rd`=5 → 01.
- Load-use: `id_ex_memread`, `id_ex_rd`=7, `id_src[1]`=7, `id_valid` → `stall`=1 and `bubble`=1 for one cycle; `stall_cnt`=1 afterwards. Same with `id_valid`=0 → no stall.
- Multi-cycle load: `ex_mem_memread`=1, `mem_ready` low for 5 cycles then high → `stall`=1 for 5 cycles, 0 on the 6th cycle, `bubble`=0 throughout, `stall_cnt`=5.
- Timeout: MEM_TIMEOUT=16, `mem_ready` held low → `mem_err`=1 from cycle 16 onward and `stall` stays 1 even after `mem_ready` rises. `rst_n` low for one edge → `mem_err`=0, `stall_cnt`=0, state RUN.
- Saturation: CNT_W=4 with 20 stall cycles → `stall_cnt`=15. Simultaneous `load_use` and `mem_busy` → `stall`=1, `bubble`=0.
